// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one start/done 8x8 multiplier among NUM_REQ requesters.
// Optional WAIT timeout is built when MUL_ARB_TIMEOUT_EN is defined.
module mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   a_in,
    input  logic [8*NUM_REQ-1:0]   b_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [7:0]             mul_a,
    output logic [7:0]             mul_b,
    input  logic                   mul_done,
    input  logic [15:0]            mul_result
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mul_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;

    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win;
    logic [PW-1:0] win_next;
    logic          any_req;
    int            sel_idx;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        sel_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_idx = (int'(ptr) + i) % NUM_REQ;
            if (!any_req && req[sel_idx]) begin
                any_req = 1'b1;
                win     = PW'(sel_idx);
            end
        end
        win_next = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mul_start <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                // RESP re-arbitrates so back-to-back ops skip IDLE.
                IDLE, RESP: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        gnt       <= ONE_HOT0 << win;
                        mul_start <= 1'b1;
                        mul_a     <= a_in[8*int'(win) +: 8];
                        mul_b     <= b_in[8*int'(win) +: 8];
                        owner     <= win;
                        ptr       <= win_next;
                        busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (mul_done) begin
                        state      <= RESP;
                        rsp_valid  <= ONE_HOT0 << owner;
                        rsp_result <= mul_result;
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        state      <= RESP;
                        rsp_valid  <= ONE_HOT0 << owner;
                        rsp_result <= 16'h0000;
                        err_q      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
